// File: rtl/kpg_pkg.sv
// Shared types for the KPG serial adder: carry symbols,
// FSM state encoding and the per-bit symbol helper.
package kpg_pkg;

  typedef logic [1:0] kpg_t;

  // 2'b10 is never produced; consumers treat it as KILL
  localparam kpg_t KILL = 2'b00;
  localparam kpg_t PROP = 2'b01;
  localparam kpg_t GEN  = 2'b11;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'b00;
  localparam state_t RUN  = 2'b01;
  localparam state_t DONE = 2'b10;

  function automatic kpg_t kpg_of(
    input logic a,
    input logic b
  );
    kpg_t s;
    s = KILL;
    if (a & b)
      s = GEN;
    else if (a ^ b)
      s = PROP;
    return s;
  endfunction

endpackage

// File: rtl/kpg_step.sv
// One bit-slice of the KPG adder: sum bit and next carry symbol.
// Ports: a_bit, b_bit, carry_state in; sum_bit, next_carry_state out.
module kpg_step
  import kpg_pkg::*;
(
  input  logic a_bit,
  input  logic b_bit,
  input  kpg_t carry_state,
  output logic sum_bit,
  output kpg_t next_carry_state
);

  kpg_t sym;
  logic c_in;

  // only an exact GEN counts as a carry; anything else is KILL
  assign c_in = (carry_state == GEN);
  assign sym  = kpg_of(a_bit, b_bit);

  assign sum_bit = a_bit ^ b_bit ^ c_in;

  assign next_carry_state =
    (sym == PROP) ? (c_in ? GEN : KILL) : sym;

endmodule

// File: rtl/kpg_serial_adder.sv
// Bit-serial KPG adder, LSB first, valid/ready on both sides.
// Ports: clk, rst (async high), in_valid/in_ready/a/b/cin,
// out_valid/out_ready/sum/cout, ovf when KPG_ADD_OVF_EN is defined.
module kpg_serial_adder
  import kpg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef KPG_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  kpg_t            carry_q;

  logic            s_bit;
  kpg_t            c_next;

  kpg_step u_step (
    .a_bit            (a_q[0]),
    .b_bit            (b_q[0]),
    .carry_state      (carry_q),
    .sum_bit          (s_bit),
    .next_carry_state (c_next)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign sum       = sum_q;
  assign cout      = (carry_q == GEN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= KILL;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin ? GEN : KILL;
            cnt     <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          // sum enters at the MSB so it is LSB-aligned after WIDTH shifts
          sum_q   <= {s_bit, sum_q[WIDTH-1:1]};
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          carry_q <= c_next;
          if (cnt == LAST)
            state <= DONE;
          else
            cnt <= cnt + CW'(1);
        end
        DONE: begin
          if (out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef KPG_ADD_OVF_EN
  logic ovf_q;

  // on the last bit carry_q is the carry into the MSB
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ovf_q <= 1'b0;
    else if (state == RUN && cnt == LAST)
      ovf_q <= (carry_q == GEN) ^ (c_next == GEN);
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: doc/kpg_serial_adder.md
# kpg_serial_adder

Bit-serial adder that resolves kill/propagate/generate (KPG) carry symbols one bit per cycle, LSB first, and assembles the sum word. It is the sequential counterpart of the parallel KPG prefix-combine cells in the multiplier datapath. It is used where area matters more than latency, such as partial-product accumulation in the low-area multiplier variant. Operands enter and results leave through valid/ready handshakes.

## Interface
- WIDTH, 8: operand and sum width in bits, ≥ 2
- clk  in  1: clock, rising-edge
- rst  in  1: asynchronous, active-high reset
- in_valid  in  1: operands a, b, cin valid
- in_ready  out  1: block can accept operands
- a  in  WIDTH: operand A
- b  in  WIDTH: operand B
- cin  in  1: carry-in
- out_valid  out  1: sum, cout (and ovf) valid
- out_ready  in  1: consumer accepts result
- sum  out  WIDTH: a + b + cin, low WIDTH bits
- cout  out  1: carry out of bit WIDTH-1
- ovf  out  1: signed overflow (only with KPG_ADD_OVF_EN)

## Operation
- KPG encoding: KILL=2'b00, PROP=2'b01, GEN=2'b11. 2'b10 is illegal and is treated as KILL.
- Per-bit symbol:
  - a[i]&b[i] gives GEN
  - a[i]^b[i] gives PROP
  - otherwise KILL
- Combine rule: new = (bit == PROP) ? carry_state : bit.
- The carry state register holds only KILL or GEN.
- FSM states:
  - IDLE: in_ready=1. When in_valid&in_ready, latch a and b, set carry_state = cin ? GEN : KILL, set bit counter=0, go to RUN.
  - RUN: each cycle processes bit[counter]:
    - sum_bit = a[i]^b[i]^(carry_state==GEN), shifted into sum register MSB-ward (ends LSB-aligned).
    - carry_state ← combine(bit symbol, carry_state).
    - counter increments. After bit WIDTH-1, go to DONE.
  - DONE: out_valid=1, and sum/cout are held stable. When out_ready, go to IDLE.
- cout = (final carry_state == GEN).
- in_ready is low in RUN and DONE. There is no overlap of operations.
- in_valid while not ready is ignored. Operands are sampled only at the accepting edge; later changes to a, b, cin have no effect.

## Timing
- Reset values:
  - in_ready=1, out_valid=0, sum=0, cout=0, ovf=0
  - state=IDLE, counter=0, carry_state=KILL
- Handshakes are ignored while rst is high.
- Latency: with the accepting edge as edge 0, edges 1..WIDTH process bits 0..WIDTH-1. out_valid is high after edge WIDTH.
- Throughput: one result per WIDTH+2 cycles when out_ready is held high.
- Counter is ceil(log2(WIDTH)) bits. It does not wrap: the transition to DONE happens at counter==WIDTH-1.
- Reset mid-RUN or mid-DONE: the operation is discarded immediately (asynchronous). out_valid drops without a handshake, and the FSM returns to IDLE.
- out_ready high outside DONE has no effect.
- The DONE→IDLE edge and a new in_valid do not combine: new operands are accepted at the earliest one edge after leaving DONE.

## Configuration
- KPG_ADD_OVF_EN defined:
  - The ovf port exists.
  - ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
  - ovf is registered with cout, valid with out_valid, and cleared on reset.
- KPG_ADD_OVF_EN undefined: the ovf port and its register are absent. All other behaviour is identical.

## Structure
- Shared package kpg_pkg holds:
  - KPG symbol typedef and the KILL/PROP/GEN constants
  - FSM state typedef (IDLE/RUN/DONE)
- Sub-module kpg_step (combinational): inputs a_bit, b_bit, carry_state; outputs sum_bit, next_carry_state. It is reusable by a future multi-bit-per-cycle variant.
- Top level holds the FSM, counter, operand and sum shift registers, and the handshake logic.

## Test plan
- a=0x0F, b=0x01, cin=0 → sum=0x10, cout=0. out_valid rises exactly after the 8th edge following acceptance.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1 (full propagate chain).
- a=0xFF, b=0x00, cin=1 → sum=0x00, cout=1. a=0x00, b=0x00, cin=1 → sum=0x01, cout=0.
- Backpressure: result of a=0x35, b=0x4A (sum=0x7F) with out_ready low for 5 cycles → sum and cout held, in_ready=0, and a second in_valid is not accepted until one edge after the out handshake.
- Reset asserted asynchronously while processing bit 3 → out_valid=0 and in_ready=1 immediately. A following a=0x12, b=0x34 gives sum=0x46.
- With KPG_ADD_OVF_EN:
  - a=0x7F, b=0x01 → sum=0x80, ovf=1, cout=0.
  - a=0x80, b=0x80 → sum=0x00, ovf=1, cout=1.
